// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types for the ALU arbiter and its picker.
package cpu_pkg;
  localparam int ALU_ARB_NUM_REQ = 2;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_function_t;
  typedef enum logic [2:0] {R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE} instruction_type_t;
  typedef enum logic {ST_EMPTY, ST_FULL} arb_state_t;
endpackage

// File: rtl/alu_arb_rr_pick.sv
// alu_arb_rr_pick: two-way picker, a lone valid wins, on contention the pointed port wins.
module alu_arb_rr_pick
  import cpu_pkg::*;
(
  input  logic [ALU_ARB_NUM_REQ-1:0] i_valid,
  input  logic                       i_ptr,
  output logic [ALU_ARB_NUM_REQ-1:0] o_grant
);
  assign o_grant[0] = i_valid[0] & (~i_valid[1] | ~i_ptr);
  assign o_grant[1] = i_valid[1] & (~i_valid[0] | i_ptr);
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between two requesters and returns a registered result.
// Define ALU_ARB_FIXED_PRIO_EN to make port 0 always win contention (no round-robin pointer).
module alu_share_arbiter
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  alu_function_t   req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  alu_function_t   req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_result,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_result,
  output alu_function_t   alu_control,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result
);
  arb_state_t r_state, w_state_nxt;
  logic r_owner;
  logic [XLEN-1:0] r_result;
  logic w_own_rdy, w_can_accept, w_any, w_win, w_ptr;
  logic [ALU_ARB_NUM_REQ-1:0] w_grant;
  assign w_own_rdy = r_owner ? rsp1_ready : rsp0_ready;
  // Reset also blocks grants so the ALU sees ADD 0,0 while rst is high.
  assign w_can_accept = !rst && (r_state == ST_EMPTY || w_own_rdy);
  alu_arb_rr_pick u_pick (
    .i_valid({req1_valid, req0_valid} & {ALU_ARB_NUM_REQ{w_can_accept}}),
    .i_ptr  (w_ptr),
    .o_grant(w_grant)
  );
  assign w_any = |w_grant;
  assign w_win = w_grant[1];
  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign alu_control = w_any ? (w_win ? req1_op : req0_op) : ALU_ADD;
  assign alu_a = w_any ? (w_win ? req1_a : req0_a) : '0;
  assign alu_b = w_any ? (w_win ? req1_b : req0_b) : '0;
  assign rsp0_valid = (r_state == ST_FULL) && !r_owner;
  assign rsp1_valid = (r_state == ST_FULL) && r_owner;
  assign rsp0_result = r_result;
  assign rsp1_result = r_result;
  always_comb begin
    w_state_nxt = (w_any || (r_state == ST_FULL && !w_own_rdy)) ? ST_FULL : ST_EMPTY;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_EMPTY;
      r_owner  <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_any) begin
        r_owner  <= w_win;
        r_result <= alu_result;
      end
    end
  end
`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_ptr = 1'b0;
`else
  logic r_ptr;
  assign w_ptr = r_ptr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ptr <= 1'b0;
    else if (w_any) r_ptr <= ~w_win;
  end
`endif
endmodule
